// File: rtl/multiport_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multiport_fifo_pkg
//  Purpose  : Shared helpers for the multi-lane in-order FIFO: pointer width,
//             leading-ones run length and unsigned minimum.
//  Revision : 1.0  initial release
// ============================================================================
package multiport_fifo_pkg;

  // Widest lane vector the run-length helper accepts
  localparam int LANE_VEC_W = 32;

  // Pointer width: address bits plus one wrap bit
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Length of the unbroken run of 1s starting at bit 0
  function automatic int lead_ones(input logic [LANE_VEC_W-1:0] vec);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < LANE_VEC_W; i++) begin
      if (run && vec[i]) n++;
      else               run = 1'b0;
    end
    return n;
  endfunction

  function automatic int min_u(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage : multiport_fifo_pkg
`default_nettype wire

// File: rtl/multiport_fifo_rotator.sv
`default_nettype none
// ============================================================================
//  Module   : multiport_fifo_rotator
//  Purpose  : Barrel rotation of PORT_NUM lanes: out[j] = in[(j - shift) mod
//             PORT_NUM]. Used lane->bank on writes and bank->lane on reads.
//  Revision : 1.0  initial release
// ============================================================================
module multiport_fifo_rotator
  import multiport_fifo_pkg::*;
#(
  parameter int PORT_NUM = 4,
  parameter int WIDTH    = 64
) (
  input  logic [$clog2(PORT_NUM)-1:0] shift,
  input  logic [PORT_NUM*WIDTH-1:0]   in_lanes,
  output logic [PORT_NUM*WIDTH-1:0]   out_lanes
);

  localparam int SW = $clog2(PORT_NUM);

  generate
    for (genvar j = 0; j < PORT_NUM; j++) begin : g_lane
      logic [SW-1:0] src;
      // Source lane wraps naturally because PORT_NUM is a power of two
      assign src = SW'(j) - shift;
      assign out_lanes[j*WIDTH +: WIDTH] = in_lanes[src*WIDTH +: WIDTH];
    end
  endgenerate

endmodule : multiport_fifo_rotator
`default_nettype wire

// File: rtl/multiport_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : multiport_fifo
//  Purpose  : In-order FIFO, PORT_NUM write lanes and PORT_NUM read lanes,
//             first-word fall-through reads, banked storage.
//  Config   : MULTIPORT_FIFO_CHECK_EN adds err_sticky and a count assertion.
//  Revision : 1.0  initial release
// ============================================================================
module multiport_fifo
  import multiport_fifo_pkg::*;
#(
  parameter int PORT_NUM  = 4,
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [PORT_NUM*WIDTH-1:0] data_in,
  input  logic [PORT_NUM-1:0]       data_in_valid,
  input  logic                      push,
  output logic [PORT_NUM-1:0]       data_in_enable,
  output logic [PORT_NUM*WIDTH-1:0] data_out,
  output logic [PORT_NUM-1:0]       data_out_valid,
  input  logic [PORT_NUM-1:0]       data_pop_valid,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    count
`ifdef MULTIPORT_FIFO_CHECK_EN
  ,
  output logic                      err_sticky
`endif
);

  localparam int PW   = ptr_width(DEPTH);
  localparam int AW   = $clog2(DEPTH);
  localparam int LP   = $clog2(PORT_NUM);
  localparam int ROWS = DEPTH / PORT_NUM;
  localparam int RW   = (AW > LP) ? (AW - LP) : 1;

  logic [PW-1:0] rptr, wptr, free, n_push, n_pop;
  int            cap_push, cap_pop;
  logic [LP-1:0] woff, roff, rd_shift;
  logic [PORT_NUM*WIDTH-1:0] wr_banks, rd_banks;

  assign count       = wptr - rptr;
  assign free        = PW'(DEPTH) - count;
  assign full        = (count == PW'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= PW'(AF_THRESH));

  // Lane limits and accepted push/pop counts; space freed by pops this cycle is not reused
  always_comb begin
    cap_push       = min_u(PORT_NUM, int'(free));
    cap_pop        = min_u(PORT_NUM, int'(count));
    n_push         = '0;
    n_pop          = '0;
    data_in_enable = '0;
    data_out_valid = '0;
    if (push) n_push = PW'(min_u(lead_ones(LANE_VEC_W'(data_in_valid)), cap_push));
    if (pop)  n_pop  = PW'(min_u(lead_ones(LANE_VEC_W'(data_pop_valid)), cap_pop));
    for (int i = 0; i < PORT_NUM; i++) begin
      data_in_enable[i] = (i < cap_push);
      data_out_valid[i] = (i < cap_pop);
    end
  end

  // Pointer update; flush wins over push and pop, reset clears immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr <= '0;
      wptr <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      wptr <= wptr + n_push;
      rptr <= rptr + n_pop;
    end
  end

  assign woff     = wptr[LP-1:0];
  assign roff     = rptr[LP-1:0];
  assign rd_shift = LP'(0) - roff;

  multiport_fifo_rotator #(.PORT_NUM(PORT_NUM), .WIDTH(WIDTH)) u_wr_rot (
    .shift     (woff),
    .in_lanes  (data_in),
    .out_lanes (wr_banks)
  );

  multiport_fifo_rotator #(.PORT_NUM(PORT_NUM), .WIDTH(WIDTH)) u_rd_rot (
    .shift     (rd_shift),
    .in_lanes  (rd_banks),
    .out_lanes (data_out)
  );

  generate
    for (genvar j = 0; j < PORT_NUM; j++) begin : g_bank
      logic [LP-1:0]    wr_lane, rd_lane;
      logic [AW-1:0]    wr_addr, rd_addr;
      logic             bank_we;
      logic [WIDTH-1:0] mem [ROWS];

      // Lane that maps onto this bank, and the entry address it targets
      assign wr_lane = LP'(j) - woff;
      assign wr_addr = wptr[AW-1:0] + AW'(wr_lane);
      assign bank_we = (PW'(wr_lane) < n_push) && !flush && rst;
      assign rd_lane = LP'(j) - roff;
      assign rd_addr = rptr[AW-1:0] + AW'(rd_lane);

      // One write per bank per cycle; contents survive flush and reset
      always_ff @(posedge clk) begin
        if (bank_we) mem[RW'(wr_addr >> LP)] <= wr_banks[j*WIDTH +: WIDTH];
      end

      assign rd_banks[j*WIDTH +: WIDTH] = mem[RW'(rd_addr >> LP)];
    end
  endgenerate

`ifdef MULTIPORT_FIFO_CHECK_EN
  logic pop_err, push_err;

  // Requests on lanes beyond what the FIFO can serve this cycle
  always_comb begin
    pop_err  = 1'b0;
    push_err = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (pop && data_pop_valid[i] && (PW'(i) >= count)) pop_err = 1'b1;
      if (push && data_in_valid[i] && !data_in_enable[i]) push_err = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      err_sticky <= 1'b0;
    else if (pop_err || push_err)  err_sticky <= 1'b1;
  end

  // Occupancy can never exceed capacity
  always_ff @(posedge clk) begin
    if (rst) assert (count <= PW'(DEPTH)) else $error("multiport_fifo: count exceeds DEPTH");
  end
`endif

endmodule : multiport_fifo
`default_nettype wire
